// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and payload types for the common-data-bus producer.
package cdb_arbiter_pkg;

  localparam int unsigned ROB_IDX_W = 5;
  localparam int unsigned CDB_VAL_W = 32;

  // Broadcast beat as seen by every CDB listener.
  typedef struct packed {
    logic [ROB_IDX_W-1:0] dest_rob;
    logic [CDB_VAL_W-1:0] value;
    logic                 valid;
  } data_bus_t;

  // One buffered result inside a per-source FIFO.
  typedef struct packed {
    logic [ROB_IDX_W-1:0] dest_rob;
    logic [CDB_VAL_W-1:0] value;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-source and broadcast signals of the CDB arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned N_SRC = 4
);
  import cdb_arbiter_pkg::*;

  localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic                           flush;
  logic [N_SRC-1:0]               src_valid;
  logic [N_SRC*ROB_IDX_W-1:0]     src_rob;
  logic [N_SRC*CDB_VAL_W-1:0]     src_value;
  logic [N_SRC-1:0]               src_ready;
  logic                           cdb_valid;
  logic [ROB_IDX_W-1:0]           cdb_rob;
  logic [CDB_VAL_W-1:0]           cdb_value;
  logic [SRC_W-1:0]               cdb_src;

  // Arbiter side
  modport slave (
    input  flush, src_valid, src_rob, src_value,
    output src_ready, cdb_valid, cdb_rob, cdb_value, cdb_src
  );

  // Functional-unit / listener side
  modport master (
    output flush, src_valid, src_rob, src_value,
    input  src_ready, cdb_valid, cdb_rob, cdb_value, cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_src_fifo.sv
// Per-source in-order result FIFO with synchronous flush.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  cdb_entry_t       i_data,
  output cdb_entry_t       o_head_c,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full_c,
  output logic             o_empty_c
);

  cdb_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_head_c  = r_mem[r_rd];
  assign o_count   = r_count;
  assign w_do_push = i_push & ~o_full_c & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty_c & ~i_flush;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + PTR_W'(1);
      if (w_do_pop)  r_rd <= r_rd + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus producer: per-source FIFOs, round-robin grant, registered
// broadcast beat. Define CDB_BYPASS_EN to let an incoming result bypass its
// empty FIFO straight into the output register.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  cdb_arbiter_if.slave  bus
);

  localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  cdb_entry_t       w_in        [N_SRC];
  cdb_entry_t       w_fifo_head [N_SRC];
  cdb_entry_t       w_head      [N_SRC];
  logic [CNT_W-1:0] w_count     [N_SRC];
  logic [N_SRC-1:0] w_full;
  logic [N_SRC-1:0] w_empty;
  logic [N_SRC-1:0] w_accept;
  logic [N_SRC-1:0] w_byp;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_sel;
  logic [N_SRC-1:0] w_push;
  logic [N_SRC-1:0] w_pop;
  logic             w_gnt_vld;
  logic [SRC_W-1:0] w_gnt_idx;
  logic [SRC_W-1:0] w_scan;
  logic [SRC_W-1:0] w_ptr_nxt;
  cdb_entry_t       w_gnt_entry;
  logic [SRC_W-1:0] r_ptr;
  logic [SRC_W-1:0] r_src;
  data_bus_t        r_beat;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign w_in[g] = '{dest_rob: bus.src_rob[g*ROB_IDX_W +: ROB_IDX_W],
                       value:    bus.src_value[g*CDB_VAL_W +: CDB_VAL_W]};
    // Ready reflects occupancy only, never a same-cycle pop.
    assign bus.src_ready[g] = ~w_full[g] & ~rst;
    assign w_accept[g]      = bus.src_valid[g] & bus.src_ready[g] & ~bus.flush;
`ifdef CDB_BYPASS_EN
    assign w_byp[g]  = w_empty[g] & w_accept[g];
    assign w_head[g] = w_empty[g] ? w_in[g] : w_fifo_head[g];
`else
    assign w_byp[g]  = 1'b0;
    assign w_head[g] = w_fifo_head[g];
`endif
    assign w_elig[g] = ~w_empty[g] | w_byp[g];
    assign w_sel[g]  = w_gnt_vld & (w_gnt_idx == SRC_W'(g));
    assign w_pop[g]  = w_sel[g] & ~w_empty[g];
    // A bypassed beat is consumed by the output register, not enqueued.
    assign w_push[g] = w_accept[g] & ~(w_sel[g] & w_byp[g]);

    cdb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_flush   (bus.flush),
      .i_push    (w_push[g]),
      .i_pop     (w_pop[g]),
      .i_data    (w_in[g]),
      .o_head_c  (w_fifo_head[g]),
      .o_count   (w_count[g]),
      .o_full_c  (w_full[g]),
      .o_empty_c (w_empty[g])
    );
  end

  // Round-robin: first eligible source scanning upward from r_ptr, wrapping.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      w_scan = SRC_W'((32'(r_ptr) + k) % N_SRC);
      if (!w_gnt_vld && w_elig[w_scan]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
  end

  assign w_gnt_entry = w_head[w_gnt_idx];
  assign w_ptr_nxt   = (w_gnt_idx == SRC_W'(N_SRC - 1)) ? '0 : w_gnt_idx + SRC_W'(1);

  // Output register and RR pointer; flush beats any grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
      r_src  <= '0;
      r_ptr  <= '0;
    end else if (bus.flush) begin
      r_beat.valid <= 1'b0;
      r_ptr        <= '0;
    end else if (w_gnt_vld) begin
      r_beat <= '{dest_rob: w_gnt_entry.dest_rob, value: w_gnt_entry.value, valid: 1'b1};
      r_src  <= w_gnt_idx;
      r_ptr  <= w_ptr_nxt;
    end else begin
      r_beat.valid <= 1'b0;
    end
  end

  assign bus.cdb_valid = r_beat.valid;
  assign bus.cdb_rob   = r_beat.dest_rob;
  assign bus.cdb_value = r_beat.value;
  assign bus.cdb_src   = r_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter with a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 4;
  localparam int D = 2;
`ifdef CDB_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_SRC(N)) bus ();
  cdb_arbiter #(.N_SRC(N), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one queue of {rob,value} per source plus RR pointer.
  logic [36:0] mq [N][$];
  int          m_ptr;
  logic        m_valid;
  logic [4:0]  m_rob;
  logic [31:0] m_val;
  logic [1:0]  m_src;

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_ptr = 0; m_valid = 1'b0; m_rob = '0; m_val = '0; m_src = '0;
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mq[i].size() < D) && !rst;
    return r;
  endfunction

  // Apply one clock edge to the model using the inputs present at the edge.
  task automatic model_edge();
    logic [N-1:0] acc;
    logic [36:0]  head;
    int           g;
    if (bus.flush) begin
      model_reset_queues();
      m_ptr = 0; m_valid = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++) acc[i] = bus.src_valid[i] && (mq[i].size() < D);
    g = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (g < 0 && (mq[i].size() > 0 || (BYP && acc[i]))) g = i;
    end
    if (g >= 0) begin
      if (mq[g].size() > 0) head = mq[g].pop_front();
      else begin
        head   = {bus.src_rob[5*g +: 5], bus.src_value[32*g +: 32]};
        acc[g] = 1'b0;
      end
      m_valid = 1'b1; m_rob = head[36:32]; m_val = head[31:0]; m_src = 2'(g);
      m_ptr = (g + 1) % N;
    end else m_valid = 1'b0;
    for (int i = 0; i < N; i++)
      if (acc[i]) mq[i].push_back({bus.src_rob[5*i +: 5], bus.src_value[32*i +: 32]});
  endtask

  task automatic model_reset_queues();
    for (int i = 0; i < N; i++) mq[i].delete();
  endtask

  task automatic drive(input logic [N-1:0] v, input logic f);
    bus.src_valid = v;
    bus.flush     = f;
    for (int i = 0; i < N; i++) begin
      bus.src_rob[5*i +: 5]    = 5'($urandom);
      bus.src_value[32*i +: 32] = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive('0, 1'b0);
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.cdb_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", bus.cdb_valid); end
    n_vec++;
    if (bus.src_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got %b exp 0000", bus.src_ready); end
    rst = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (bus.src_ready !== 4'b1111 || bus.cdb_valid !== 1'b0) begin
      n_err++; $display("FAIL release got rdy=%b v=%b exp rdy=1111 v=0", bus.src_ready, bus.cdb_valid);
    end
  endtask

  task automatic test_single();
    int beats = 0;
    int first = -1;
    drive(4'b0010, 1'b0);
    bus.src_rob[5 +: 5]    = 5'd7;
    bus.src_value[32 +: 32] = 32'hDEAD_BEEF;
    for (int c = 1; c <= 5; c++) begin
      tick();
      drive('0, 1'b0);
      n_vec++;
      if ({bus.cdb_valid, bus.cdb_rob, bus.cdb_value, bus.cdb_src, bus.src_ready} !==
          {m_valid, m_rob, m_val, m_src, model_ready()}) begin
        n_err++; $display("FAIL single_beat c=%0d got v=%b rob=%0d val=%h src=%0d rdy=%b exp v=%b rob=%0d val=%h src=%0d rdy=%b",
          c, bus.cdb_valid, bus.cdb_rob, bus.cdb_value, bus.cdb_src, bus.src_ready, m_valid, m_rob, m_val, m_src, model_ready());
      end
      if (bus.cdb_valid) begin
        beats++;
        if (first < 0) begin
          first = c;
          n_vec++;
          if (bus.cdb_rob !== 5'd7 || bus.cdb_value !== 32'hDEAD_BEEF || bus.cdb_src !== 2'd1) begin
            n_err++; $display("FAIL single_data got rob=%0d val=%h src=%0d exp 7/deadbeef/1", bus.cdb_rob, bus.cdb_value, bus.cdb_src);
          end
        end
      end
    end
    n_vec++;
    if (beats !== 1 || first !== LAT) begin
      n_err++; $display("FAIL single_count got beats=%0d cycle=%0d exp beats=1 cycle=%0d", beats, first, LAT);
    end
  endtask

  task automatic test_fairness();
    int          nb = 0;
    logic [N-1:0] seen_low = '0;
    drive('0, 1'b1); tick();
    for (int c = 0; c < 14; c++) begin
      drive(4'b1111, 1'b0);
      tick();
      n_vec++;
      if ({bus.cdb_valid, bus.cdb_rob, bus.cdb_value, bus.cdb_src, bus.src_ready} !==
          {m_valid, m_rob, m_val, m_src, model_ready()}) begin
        n_err++; $display("FAIL fair_beat c=%0d got v=%b rob=%0d val=%h src=%0d rdy=%b exp v=%b rob=%0d val=%h src=%0d rdy=%b",
          c, bus.cdb_valid, bus.cdb_rob, bus.cdb_value, bus.cdb_src, bus.src_ready, m_valid, m_rob, m_val, m_src, model_ready());
      end
      if (bus.cdb_valid) begin
        n_vec++;
        if (bus.cdb_src !== 2'(nb % N)) begin n_err++; $display("FAIL fair_order beat=%0d got src=%0d exp %0d", nb, bus.cdb_src, nb % N); end
        nb++;
      end
      seen_low |= ~bus.src_ready;
    end
    n_vec++;
    if (seen_low !== 4'b1111) begin n_err++; $display("FAIL fair_full got lowmask=%b exp 1111", seen_low); end
  endtask

  task automatic test_full();
    logic [4:0] want [3];
    logic [4:0] got [$];
    int         k = 0;
    bit         stall = 1'b0;
    bit         acc2;
    want[0] = 5'd3; want[1] = 5'd4; want[2] = 5'd5;
    drive('0, 1'b1); tick();
    for (int c = 0; c < 40; c++) begin
      drive((k < 3) ? 4'b1111 : 4'b0000, 1'b0);
      if (k < 3) bus.src_rob[10 +: 5] = want[k];
      if (k == 2 && !bus.src_ready[2]) stall = 1'b1;
      acc2 = (k < 3) && bus.src_ready[2];
      tick();
      if (acc2) k++;
      n_vec++;
      if ({bus.cdb_valid, bus.cdb_rob, bus.cdb_value, bus.cdb_src, bus.src_ready} !==
          {m_valid, m_rob, m_val, m_src, model_ready()}) begin
        n_err++; $display("FAIL full_beat c=%0d got v=%b rob=%0d val=%h src=%0d rdy=%b exp v=%b rob=%0d val=%h src=%0d rdy=%b",
          c, bus.cdb_valid, bus.cdb_rob, bus.cdb_value, bus.cdb_src, bus.src_ready, m_valid, m_rob, m_val, m_src, model_ready());
      end
      if (bus.cdb_valid && bus.cdb_src == 2'd2) got.push_back(bus.cdb_rob);
    end
    n_vec++;
    if (got.size() != 3 || got[0] !== 5'd3 || got[1] !== 5'd4 || got[2] !== 5'd5 || !stall) begin
      n_err++; $display("FAIL full_order got n=%0d first=%0d stall=%b exp 3,4,5 stall=1", got.size(),
        (got.size() > 0) ? got[0] : 5'd0, stall);
    end
  endtask

  task automatic test_flush();
    int first = -1;
    drive('0, 1'b1); tick();
    drive(4'b0111, 1'b0); tick();
    drive(4'b1000, 1'b1);
    bus.src_value[96 +: 32] = 32'hF1F1_0009;
    tick();
    n_vec++;
    if (bus.cdb_valid !== 1'b0 || bus.src_ready !== 4'b1111) begin
      n_err++; $display("FAIL flush_clear got v=%b rdy=%b exp v=0 rdy=1111", bus.cdb_valid, bus.src_ready);
    end
    for (int c = 0; c < 4; c++) begin
      drive('0, 1'b0); tick();
      n_vec++;
      if (bus.cdb_valid !== m_valid || (bus.cdb_valid && bus.cdb_value === 32'hF1F1_0009)) begin
        n_err++; $display("FAIL flush_drop c=%0d got v=%b val=%h exp v=%b", c, bus.cdb_valid, bus.cdb_value, m_valid);
      end
    end
    drive(4'b1100, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      drive('0, 1'b0);
      n_vec++;
      if ({bus.cdb_valid, bus.cdb_rob, bus.cdb_value, bus.cdb_src} !== {m_valid, m_rob, m_val, m_src}) begin
        n_err++; $display("FAIL flush_resume c=%0d got v=%b rob=%0d src=%0d exp v=%b rob=%0d src=%0d",
          c, bus.cdb_valid, bus.cdb_rob, bus.cdb_src, m_valid, m_rob, m_src);
      end
      if (bus.cdb_valid && first < 0) first = int'(bus.cdb_src);
    end
    n_vec++;
    if (first !== 2) begin n_err++; $display("FAIL flush_restart got src=%0d exp 2", first); end
  endtask

  task automatic test_midreset();
    drive('0, 1'b1); tick();
    for (int c = 0; c < 6; c++) begin drive(4'b1111, 1'b0); tick(); end
    #2 rst = 1'b1;
    drive('0, 1'b0);
    #1;
    n_vec++;
    if ({bus.cdb_valid, bus.cdb_rob, bus.cdb_value, bus.cdb_src, bus.src_ready} !== 44'd0) begin
      n_err++; $display("FAIL midrst_out got v=%b rob=%0d val=%h src=%0d rdy=%b exp all zero",
        bus.cdb_valid, bus.cdb_rob, bus.cdb_value, bus.cdb_src, bus.src_ready);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.src_ready !== 4'b1111) begin n_err++; $display("FAIL midrst_ready got %b exp 1111", bus.src_ready); end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if (bus.cdb_valid !== 1'b0 || bus.src_ready !== 4'b1111) begin
        n_err++; $display("FAIL midrst_empty c=%0d got v=%b rdy=%b exp v=0 rdy=1111", c, bus.cdb_valid, bus.src_ready);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive(4'($urandom), ($urandom_range(0, 19) == 0));
      tick();
      n_vec++;
      if ({bus.cdb_valid, bus.cdb_rob, bus.cdb_value, bus.cdb_src, bus.src_ready} !==
          {m_valid, m_rob, m_val, m_src, model_ready()}) begin
        n_err++; $display("FAIL rand_beat c=%0d got v=%b rob=%0d val=%h src=%0d rdy=%b exp v=%b rob=%0d val=%h src=%0d rdy=%b",
          c, bus.cdb_valid, bus.cdb_rob, bus.cdb_value, bus.cdb_src, bus.src_ready, m_valid, m_rob, m_val, m_src, model_ready());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_full();
    test_flush();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
